// File: rtl/stage_fetch.sv
// Instruction fetch stage: issues sequential reads, tracks up to two in-flight
// responses and buffers returned words in a 2-entry PC-tagged FIFO for decode.
module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_gnt,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid
);

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  count;

  logic [31:0] head_pc;
  logic [31:0] head_word;
  logic [31:0] tail_pc;
  logic [31:0] tail_word;

  logic        pop;
  logic        grant;
  logic        keep;
  logic [2:0]  credit_used;
  logic [31:0] target;
  logic [1:0]  outstanding_next;

  logic [31:0] head_pc_next;
  logic [31:0] head_word_next;
  logic [31:0] tail_pc_next;
  logic [31:0] tail_word_next;
  logic [1:0]  level;

  assign target      = redirect_pc & ~32'h0000_0003;
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & ~stall;
  assign pc_out      = head_pc;
  assign instr       = head_word;
  assign bus_addr    = fetch_pc;

  // A slot being popped this cycle returns its credit immediately, which lets a
  // 1-cycle bus sustain one instruction per cycle while still never overfilling.
  assign credit_used = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
  assign bus_req     = ~rst & ~redirect_valid & (credit_used < 3'd2);
  assign grant       = bus_req & bus_gnt;
  assign keep        = bus_rvalid & (drop == 2'd0);

  always_comb begin
    outstanding_next = outstanding;
    if (grant && !bus_rvalid) begin
      outstanding_next = outstanding + 2'd1;
    end else if (!grant && bus_rvalid && outstanding != 2'd0) begin
      outstanding_next = outstanding - 2'd1;
    end
  end

  // Pop shifts the tail forward first so a push lands in the freed slot.
  always_comb begin
    head_pc_next   = head_pc;
    head_word_next = head_word;
    tail_pc_next   = tail_pc;
    tail_word_next = tail_word;
    level          = count;
    if (pop) begin
      head_pc_next   = tail_pc;
      head_word_next = tail_word;
      level          = count - 2'd1;
    end
    if (keep) begin
      if (level == 2'd0) begin
        head_pc_next   = resp_pc;
        head_word_next = bus_rdata;
      end else begin
        tail_pc_next   = resp_pc;
        tail_word_next = bus_rdata;
      end
      level = level + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      count       <= 2'd0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= target;
        resp_pc  <= target;
        drop     <= outstanding_next;
        count    <= 2'd0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (keep) begin
          resp_pc <= resp_pc + 32'd4;
        end
        if (bus_rvalid && drop != 2'd0) begin
          drop <= drop - 2'd1;
        end
        count <= level;
      end
    end
  end

  always_ff @(posedge clk) begin
    head_pc   <= head_pc_next;
    head_word <= head_word_next;
    tail_pc   <= tail_pc_next;
    tail_word <= tail_word_next;
  end

endmodule

// File: tb/tb_stage_fetch.sv
// Directed and randomized bench for stage_fetch with an in-order bus model
// whose read data is the request address XOR a fixed pattern.
module tb_stage_fetch;

  localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic        instr_valid;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  logic        w_rst;
  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_valid;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_gnt;
  logic [31:0] w_rdata;
  logic        w_rvalid;

  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cyc;
  int          last_due;
  int          lat;
  bit          rand_gnt;
  bit          rand_lat;
  bit          track;

  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  logic [31:0] exp_pc;
  int          delivered;
  bit          prev_hold;
  logic [31:0] prev_addr;

  int          checks;
  int          passed;

  stage_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .instr(instr), .instr_valid(instr_valid),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_gnt(bus_gnt),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  stage_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(w_rst), .stall(w_stall),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .pc_out(w_pc), .instr(w_instr), .instr_valid(w_valid),
    .bus_req(w_req), .bus_addr(w_addr), .bus_gnt(w_gnt),
    .bus_rdata(w_rdata), .bus_rvalid(w_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // One bus/DUT cycle: drive the response, sample, book-keep grants, advance.
  task automatic cycle();
    int l;
    int due;
    if (q_addr.size() > 0 && q_due[0] == cyc) begin
      bus_rvalid = 1'b1;
      bus_rdata  = q_addr[0] ^ MAGIC;
    end else begin
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
    end
    bus_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    s_req   = bus_req;
    s_valid = instr_valid;
    s_addr  = bus_addr;
    s_pc    = pc_out;
    s_instr = instr;
    if (bus_rvalid) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (bus_req && bus_gnt) begin
      l   = rand_lat ? int'($urandom_range(1, 4)) : lat;
      due = (cyc + l > last_due) ? cyc + l : last_due + 1;
      last_due = due;
      q_addr.push_back(bus_addr);
      q_due.push_back(due);
    end
    if (track) begin
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (s_valid && !stall) begin
          checks++;
          if (s_pc !== exp_pc || s_instr !== (exp_pc ^ MAGIC)) begin
            $display("[TB] FAIL rand_deliver cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                     cyc, s_pc, s_instr, exp_pc, exp_pc ^ MAGIC);
            exp_pc = s_pc;
          end else passed++;
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
        if (prev_hold && s_req) begin
          checks++;
          if (s_addr !== prev_addr)
            $display("[TB] FAIL rand_addr_hold cyc=%0d got=%h exp=%h", cyc, s_addr, prev_addr);
          else passed++;
        end
      end
      prev_hold = s_req && !bus_gnt && !redirect_valid;
      prev_addr = s_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    track          = 1'b0;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    q_addr.delete();
    q_due.delete();
    cycle();
    cycle();
    rst      = 1'b0;
    cyc      = 0;
    last_due = 0;
  endtask

  task automatic test_reset();
    rand_gnt = 1'b0;
    rand_lat = 1'b0;
    lat      = 1;
    do_reset();
    checks++; if (s_req !== 1'b0) $display("[TB] FAIL reset_req got=%b exp=0", s_req); else passed++;
    checks++; if (s_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b exp=0", s_valid); else passed++;
    cycle();
    checks++; if (s_req !== 1'b1) $display("[TB] FAIL first_req got=%b exp=1", s_req); else passed++;
    checks++; if (s_addr !== 32'h100) $display("[TB] FAIL first_addr got=%h exp=00000100", s_addr); else passed++;
    checks++; if (s_valid !== 1'b0) $display("[TB] FAIL c0_valid got=%b exp=0", s_valid); else passed++;
    cycle();
    checks++; if (s_addr !== 32'h104) $display("[TB] FAIL c1_addr got=%h exp=00000104", s_addr); else passed++;
    checks++; if (s_valid !== 1'b0) $display("[TB] FAIL c1_valid got=%b exp=0", s_valid); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    for (int k = 2; k < 10; k++) begin
      cycle();
      epc = 32'h100 + 32'(4 * (k - 2));
      checks++;
      if (s_valid !== 1'b1 || s_pc !== epc || s_instr !== (epc ^ MAGIC))
        $display("[TB] FAIL stream c%0d got v=%b pc=%h instr=%h exp pc=%h", k, s_valid, s_pc, s_instr, epc);
      else passed++;
      checks++;
      if (s_addr !== 32'h100 + 32'(4 * k))
        $display("[TB] FAIL stream_addr c%0d got=%h exp=%h", k, s_addr, 32'h100 + 32'(4 * k));
      else passed++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] epcs[4];
    epcs[0] = 32'h108; epcs[1] = 32'h10C; epcs[2] = 32'h110; epcs[3] = 32'h114;
    do_reset();
    checks++; if (s_valid !== 1'b0) $display("[TB] FAIL midreset_valid got=%b exp=0", s_valid); else passed++;
    for (int k = 0; k < 4; k++) cycle();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h108)
        $display("[TB] FAIL stall_hold k=%0d got req=%b v=%b pc=%h exp req=0 v=1 pc=00000108", k, s_req, s_valid, s_pc);
      else passed++;
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== epcs[k] || s_instr !== (epcs[k] ^ MAGIC))
        $display("[TB] FAIL stall_release k=%0d got v=%b pc=%h instr=%h exp pc=%h", k, s_valid, s_pc, s_instr, epcs[k]);
      else passed++;
      if (k == 0) begin
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h110)
          $display("[TB] FAIL release_req got req=%b addr=%h exp req=1 addr=00000110", s_req, s_addr);
        else passed++;
      end
    end
  endtask

  task automatic test_redirect_latency();
    do_reset();
    lat = 3;
    cycle();
    cycle();
    checks++; if (s_addr !== 32'h104 || s_req !== 1'b1) $display("[TB] FAIL lat_c1 got req=%b addr=%h exp 1/00000104", s_req, s_addr); else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2003;
    cycle();
    checks++; if (s_req !== 1'b0) $display("[TB] FAIL lat_redirect_req got=%b exp=0", s_req); else passed++;
    redirect_valid = 1'b0;
    cycle();
    checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) $display("[TB] FAIL lat_c3 got req=%b v=%b exp 0/0", s_req, s_valid); else passed++;
    cycle();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h2000) $display("[TB] FAIL lat_target got req=%b addr=%h exp 1/00002000", s_req, s_addr); else passed++;
    cycle();
    cycle();
    cycle();
    checks++; if (s_valid !== 1'b0) $display("[TB] FAIL lat_c7_valid got=%b exp=0", s_valid); else passed++;
    cycle();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h2000 || s_instr !== (32'h2000 ^ MAGIC))
      $display("[TB] FAIL lat_first got v=%b pc=%h instr=%h exp pc=00002000", s_valid, s_pc, s_instr);
    else passed++;
    cycle();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h2004 || s_instr !== (32'h2004 ^ MAGIC))
      $display("[TB] FAIL lat_second got v=%b pc=%h instr=%h exp pc=00002004", s_valid, s_pc, s_instr);
    else passed++;
    lat = 1;
  endtask

  task automatic test_redirect_pop();
    do_reset();
    for (int k = 0; k < 4; k++) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    cycle();
    checks++; if (s_req !== 1'b0) $display("[TB] FAIL rp_req got=%b exp=0", s_req); else passed++;
    redirect_valid = 1'b0;
    cycle();
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h2000)
      $display("[TB] FAIL rp_after got v=%b req=%b addr=%h exp 0/1/00002000", s_valid, s_req, s_addr);
    else passed++;
    cycle();
    checks++; if (s_valid !== 1'b0 || s_addr !== 32'h2004) $display("[TB] FAIL rp_c2 got v=%b addr=%h exp 0/00002004", s_valid, s_addr); else passed++;
    cycle();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h2000 || s_instr !== (32'h2000 ^ MAGIC))
      $display("[TB] FAIL rp_first got v=%b pc=%h instr=%h exp pc=00002000", s_valid, s_pc, s_instr);
    else passed++;
  endtask

  task automatic test_wrap();
    logic        pend;
    logic [31:0] paddr;
    logic [31:0] epc;
    rst   = 1'b1;
    w_rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    w_rst = 1'b0;
    pend  = 1'b0;
    paddr = 32'h0;
    for (int k = 0; k < 6; k++) begin
      w_rvalid = pend;
      w_rdata  = paddr ^ MAGIC;
      #1;
      if (k >= 2 && k <= 4) begin
        epc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        checks++;
        if (w_valid !== 1'b1 || w_pc !== epc || w_instr !== (epc ^ MAGIC))
          $display("[TB] FAIL wrap c%0d got v=%b pc=%h instr=%h exp pc=%h", k, w_valid, w_pc, w_instr, epc);
        else passed++;
      end
      if (k == 2) begin
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'h0) $display("[TB] FAIL wrap_addr got req=%b addr=%h exp 1/00000000", w_req, w_addr);
        else passed++;
      end
      pend  = w_req;
      paddr = w_addr;
      @(posedge clk); #1;
    end
    w_rst = 1'b1;
  endtask

  task automatic test_random();
    rand_gnt = 1'b1;
    rand_lat = 1'b1;
    do_reset();
    exp_pc    = 32'h100;
    delivered = 0;
    prev_hold = 1'b0;
    track     = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      cycle();
    end
    track          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (delivered < 500) $display("[TB] FAIL rand_progress got=%0d exp>=500", delivered);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    cyc = 0; last_due = 0; lat = 1;
    rand_gnt = 1'b0; rand_lat = 1'b0; track = 1'b0;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    bus_gnt = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    w_rst = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_pop();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
